// File: rtl/blink_rate_meter.sv
// blink_rate_meter: measures the rising-edge period of an external blink line and classifies it as slow/fast.
// Optional glitch filter on the synchronised input, enabled by defining BLINK_RATE_METER_GLITCH_FILTER_EN.
//
// state        | meaning
// WAIT_FIRST   | no reference edge yet; next rise starts a measurement
// RUN          | reference edge seen; each rise captures a period
module blink_rate_meter #(
  parameter int CNT_W    = 27,
  parameter int P_SLOW   = 50_000_000,
  parameter int P_FAST   = 5_000_000,
  parameter int TOL      = 50_000,
  parameter int TIMEOUT  = 100_000_000,
  parameter int FILT_LEN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             is_slow,
  output logic             is_fast,
  output logic             no_signal,
  output logic             led
);

  localparam logic [0:0] S_WAIT_FIRST = 1'b0;
  localparam logic [0:0] S_RUN        = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SLOW_LO   = CNT_W'(P_SLOW - TOL);
  localparam logic [CNT_W-1:0] SLOW_HI   = CNT_W'(P_SLOW + TOL);
  localparam logic [CNT_W-1:0] FAST_LO   = CNT_W'(P_FAST - TOL);
  localparam logic [CNT_W-1:0] FAST_HI   = CNT_W'(P_FAST + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic             prev;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic             slow_hit;
  logic             fast_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
    end
  end

`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] filt_cnt;
  logic            filt;

  // Level follows sync2 only after FILT_LEN consecutive samples of the new value.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (sync2 == filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
      filt     <= sync2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  // rise is registered so the capture lands three edges after the first high sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= lvl;
      rise <= lvl & ~prev;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign slow_hit = (cnt >= SLOW_LO) && (cnt <= SLOW_HI);
  assign fast_hit = (cnt >= FAST_LO) && (cnt <= FAST_HI);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_WAIT_FIRST;
      period       <= '0;
      period_valid <= 1'b0;
      is_slow      <= 1'b0;
      is_fast      <= 1'b0;
      led          <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        S_WAIT_FIRST: begin
          if (rise) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // A rise on the timeout cycle still counts as a measurement.
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            is_slow      <= slow_hit;
            is_fast      <= fast_hit;
            led          <= slow_hit | fast_hit;
          end else if (cnt >= TIMEOUT_C) begin
            state   <= S_WAIT_FIRST;
            period  <= '0;
            is_slow <= 1'b0;
            is_fast <= 1'b0;
            led     <= 1'b0;
          end
        end
        default: state <= S_WAIT_FIRST;
      endcase
    end
  end

  assign no_signal = (state == S_WAIT_FIRST);

endmodule

// File: tb/tb_blink_rate_meter.sv
// tb_blink_rate_meter: directed blink waveforms against an edge-timeline model.
// Two DUTs share the stimulus and differ only in TIMEOUT (200 and 255, the latter saturating the counter).
`timescale 1ns/1ps
module tb_blink_rate_meter;

  localparam int CNT_W    = 8;
  localparam int P_SLOW   = 100;
  localparam int P_FAST   = 10;
  localparam int TOL      = 2;
  localparam int TO_A     = 200;
  localparam int TO_B     = 255;
  localparam int FILT_LEN = 4;
`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  logic             clock  = 1'b0;
  logic             reset  = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period [2];
  logic             period_valid [2];
  logic             is_slow [2];
  logic             is_fast [2];
  logic             no_signal [2];
  logic             led [2];

  blink_rate_meter #(.CNT_W(CNT_W), .P_SLOW(P_SLOW), .P_FAST(P_FAST), .TOL(TOL),
                     .TIMEOUT(TO_A), .FILT_LEN(FILT_LEN)) dut_a (
    .clock(clock), .reset(reset), .sig_in(sig_in),
    .period(period[0]), .period_valid(period_valid[0]), .is_slow(is_slow[0]),
    .is_fast(is_fast[0]), .no_signal(no_signal[0]), .led(led[0]));

  blink_rate_meter #(.CNT_W(CNT_W), .P_SLOW(P_SLOW), .P_FAST(P_FAST), .TOL(TOL),
                     .TIMEOUT(TO_B), .FILT_LEN(FILT_LEN)) dut_b (
    .clock(clock), .reset(reset), .sig_in(sig_in),
    .period(period[1]), .period_valid(period_valid[1]), .is_slow(is_slow[1]),
    .is_fast(is_fast[1]), .no_signal(no_signal[1]), .led(led[1]));

  always #5 clock = ~clock;

  int nvec = 0;
  int nmis = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic in_win(input int n, input int centre);
    return (n >= centre - TOL) && (n <= centre + TOL);
  endfunction

  // Model: a sampled rise becomes a capture event LAT edges later; periods are differences of capture edges.
  int   cyc = 0;
  int   pend [$];
  logic m_run [2];
  int   m_last [2];
  int   m_per [2];
  logic m_val [2];
  logic m_slow [2];
  logic m_fast [2];
`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
  logic flev = 1'b0;
  int   fcnt = 0;
`else
  logic last_s = 1'b0;
`endif

  always @(posedge clock) begin : model
    int   e;
    int   n;
    logic rn;
    cyc = cyc + 1;
    e = cyc;
    if (reset) begin
      pend.delete();
`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
      flev = 1'b0;
      fcnt = 0;
`else
      last_s = 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 1'b0; m_last[i] = 0; m_per[i] = 0;
        m_val[i] = 1'b0; m_slow[i] = 1'b0; m_fast[i] = 1'b0;
      end
    end else begin
`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
      if (sig_in != flev) begin
        fcnt++;
        if (fcnt == FILT_LEN) begin
          flev = sig_in;
          fcnt = 0;
          if (flev) pend.push_back(e + 4);
        end
      end else begin
        fcnt = 0;
      end
`else
      if (sig_in && !last_s) pend.push_back(e + 3);
      last_s = sig_in;
`endif
      rn = 1'b0;
      if (pend.size() > 0 && pend[0] == e) begin
        rn = 1'b1;
        void'(pend.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        m_val[i] = 1'b0;
        if (m_run[i]) begin
          if (rn) begin
            n = e - m_last[i];
            if (n > 255) n = 255;
            m_per[i]  = n;
            m_val[i]  = 1'b1;
            m_slow[i] = in_win(n, P_SLOW);
            m_fast[i] = in_win(n, P_FAST);
            m_last[i] = e;
          end else if (e - m_last[i] >= ((i == 0) ? TO_A : TO_B)) begin
            m_run[i] = 1'b0; m_per[i] = 0; m_slow[i] = 1'b0; m_fast[i] = 1'b0;
          end
        end else if (rn) begin
          m_run[i]  = 1'b1;
          m_last[i] = e;
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("period[%0d]", i), int'(period[i]), m_per[i]);
        check($sformatf("period_valid[%0d]", i), int'(period_valid[i]), int'(m_val[i]));
        check($sformatf("is_slow[%0d]", i), int'(is_slow[i]), int'(m_slow[i]));
        check($sformatf("is_fast[%0d]", i), int'(is_fast[i]), int'(m_fast[i]));
        check($sformatf("no_signal[%0d]", i), int'(no_signal[i]), int'(!m_run[i]));
        check($sformatf("led[%0d]", i), int'(led[i]), int'(m_slow[i] | m_fast[i]));
      end
    end
  end

  // Observation log of dut_a reports, dut_b report summary, dut_a lock-loss edge.
  int   lg_n = 0;
  int   lg_per [64];
  int   lg_cyc [64];
  logic lg_slow [64];
  logic lg_fast [64];
  logic lg_led [64];
  logic lg_ns [64];
  int   nb_valid = 0;
  int   nb_max = 0;
  int   ns_rise_cyc = -1;
  logic ns_prev = 1'b1;

  always @(negedge clock) begin : logger
    if (period_valid[0] && lg_n < 64) begin
      lg_per[lg_n]  = int'(period[0]);
      lg_cyc[lg_n]  = cyc;
      lg_slow[lg_n] = is_slow[0];
      lg_fast[lg_n] = is_fast[0];
      lg_led[lg_n]  = led[0];
      lg_ns[lg_n]   = no_signal[0];
      lg_n++;
    end
    if (period_valid[1]) begin
      nb_valid++;
      if (int'(period[1]) > nb_max) nb_max = int'(period[1]);
    end
    if (no_signal[0] && !ns_prev) ns_rise_cyc = cyc;
    ns_prev = no_signal[0];
  end

  int rz [$];

  task automatic step(input logic s);
    sig_in = s;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0);
  endtask

  task automatic pulses(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++) begin
      rz.push_back(cyc + 1);
      for (int c = 0; c < per; c++) step(c < hi);
    end
  endtask

  task automatic glitch_period();
    rz.push_back(cyc + 1);
    for (int c = 0; c < 100; c++) step((c < 50) || (c == 70) || (c == 71));
  endtask

  task automatic clear_log();
    lg_n = 0;
    rz.delete();
  endtask

  task automatic chk_entry(input int idx, input int per, input logic sl, input logic fa);
    check($sformatf("log[%0d] present", idx), int'(idx < lg_n), 1);
    if (idx < lg_n) begin
      check($sformatf("log[%0d] period", idx), lg_per[idx], per);
      check($sformatf("log[%0d] is_slow", idx), int'(lg_slow[idx]), int'(sl));
      check($sformatf("log[%0d] is_fast", idx), int'(lg_fast[idx]), int'(fa));
      check($sformatf("log[%0d] led", idx), int'(lg_led[idx]), int'(sl | fa));
    end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("reset period", int'(period[0]), 0);
    check("reset no_signal", int'(no_signal[0]), 1);
    check("reset led", int'(led[0]), 0);
    check("reset period_valid", int'(period_valid[0]), 0);
    reset = 1'b0;
    idle(5);

    // Lock onto the slow rate; first edge silent, second reports LAT edges after its sample.
    clear_log();
    pulses(100, 50, 3);
    check("t1 report count", lg_n, 2);
    chk_entry(0, 100, 1'b1, 1'b0);
    check("t1 valid latency", lg_cyc[0], rz[1] + LAT);
    check("t1 no_signal at report", int'(lg_ns[0]), 0);

    // Fast-rate window edges, then slow-rate window edges.
    clear_log();
    pulses(10, 5, 3);
    pulses(12, 6, 3);
    pulses(13, 6, 3);
    pulses(102, 51, 1);
    pulses(103, 51, 1);
    pulses(97, 48, 1);
    pulses(100, 50, 1);
    check("t2 report count", lg_n, 13);
    chk_entry(3, 10, 1'b0, 1'b1);
    chk_entry(6, 12, 1'b0, 1'b1);
    chk_entry(9, 13, 1'b0, 1'b0);
    chk_entry(10, 102, 1'b1, 1'b0);
    chk_entry(11, 103, 1'b0, 1'b0);
    chk_entry(12, 97, 1'b0, 1'b0);

    // Loss of signal after lock, then re-lock.
    clear_log();
    ns_rise_cyc = -1;
    pulses(100, 50, 2);
    idle(250);
    check("t3 report count", lg_n, 2);
    check("t3 timeout edge", ns_rise_cyc, lg_cyc[1] + TO_A);
    check("t3 no_signal", int'(no_signal[0]), 1);
    check("t3 period cleared", int'(period[0]), 0);
    check("t3 led cleared", int'(led[0]), 0);
    clear_log();
    pulses(100, 50, 3);
    check("t3 relock count", lg_n, 2);
    chk_entry(0, 100, 1'b1, 1'b0);

    // Edges 300 apart: dut_b saturates at 255 and times out before reporting it.
    nb_valid = 0;
    nb_max   = 0;
    pulses(300, 150, 3);
    idle(10);
    check("t4 dut_b report count", nb_valid, 1);
    check("t4 dut_b max period", nb_max, 100);
    check("t4 dut_b no_signal", int'(no_signal[1]), 1);

    // Reset between two edges: the next edge is a fresh first edge.
    pulses(100, 50, 2);
    for (int c = 0; c < 50; c++) step(1'b1);
    idle(20);
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    idle(29);
    check("t5 no_signal after reset", int'(no_signal[0]), 1);
    clear_log();
    pulses(100, 50, 2);
    check("t5 report count", lg_n, 1);
    chk_entry(0, 100, 1'b1, 1'b0);

    // Two-cycle high glitch 20 cycles into each low phase.
    clear_log();
    glitch_period();
    glitch_period();
    glitch_period();
    pulses(100, 50, 1);
    idle(5);
`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
    check("t6 report count", lg_n, 4);
    chk_entry(1, 100, 1'b1, 1'b0);
    chk_entry(3, 100, 1'b1, 1'b0);
`else
    check("t6 report count", lg_n, 7);
    chk_entry(0, 100, 1'b1, 1'b0);
    chk_entry(1, 70, 1'b0, 1'b0);
    chk_entry(2, 30, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
